// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request/acknowledge bus between the memory-stage controller
// and a variable-latency data memory. The controller drives the request side
// (master); the memory answers with a one-cycle dm_ack pulse carrying dm_rdata.
interface mem_stage_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller and MEM/WB pipeline register.
// Consumes the EX/MEM register, runs one req/ack access per load/store against
// the data memory, stalls the front of the pipeline while the access is open and
// writes the result into MEM/WB. A stall cycle always loads a bubble into MEM/WB,
// so each instruction reaches write-back exactly once.
// TIMEOUT counts ACCESS cycles without dm_ack before the access is abandoned
// (0 disables the abort); the wait counter is 8 bits, so TIMEOUT must be <= 255.
// Optional build macro ALIGN_CHECK_EN: when defined, a load/store whose address
// has bits [1:0] != 0 is dropped in IDLE (no request, no stall, misalign pulse,
// write-back suppressed). When undefined, misalign is tied low and the address
// is passed to the memory unchecked.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ALUresultMEM,
  input  logic [31:0]      dmemdata,
  input  logic [4:0]       writeregMEM,
  input  logic             MemReadMEM,
  input  logic             MemWriteMEM,
  input  logic             MemtoRegMEM,
  input  logic             RegWriteMEM,
  mem_stage_ctrl_if.master dmem,
  output logic             mem_stall,
  output logic [31:0]      memdataWB,
  output logic [31:0]      ALUresultWB,
  output logic [4:0]       writeregWB,
  output logic             MemtoRegWB,
  output logic             RegWriteWB,
  output logic             bus_err,
  output logic             misalign
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [8:0] TIMEOUT_VAL = 9'(TIMEOUT);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic        squash_r;
  logic [31:0] rdata_r;
  logic [31:0] alu_hold_r;
  logic [4:0]  wreg_hold_r;
  logic        m2r_hold_r;
  logic        rw_hold_r;
  logic        dm_req_r;
  logic        dm_we_r;
  logic [31:0] dm_addr_r;
  logic [31:0] dm_wdata_r;

  logic        access_s;
  logic        misalign_s;
  logic        start_s;
  logic        timeout_s;

  assign dmem.dm_req   = dm_req_r;
  assign dmem.dm_we    = dm_we_r;
  assign dmem.dm_addr  = dm_addr_r;
  assign dmem.dm_wdata = dm_wdata_r;

  // Decode the EX/MEM instruction: does it need an access, is it misaligned, has the wait expired.
  always_comb begin
    access_s = MemReadMEM | MemWriteMEM;
`ifdef ALIGN_CHECK_EN
    misalign_s = (state_r == IDLE) && access_s && (ALUresultMEM[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    start_s   = (state_r == IDLE) && access_s && !misalign_s;
    timeout_s = TIMEOUT_EN && (({1'b0, wait_cnt_r} + 9'd1) == TIMEOUT_VAL);
  end

  // Stall the front end while a new access is being launched or one is outstanding.
  always_comb begin
    mem_stall = 1'b0;
    misalign  = 1'b0;
    if (reset) begin
      mem_stall = 1'b0;
      misalign  = 1'b0;
    end else begin
      mem_stall = start_s || (state_r == ACCESS);
      misalign  = misalign_s;
    end
  end

  // Access FSM, memory request registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      squash_r    <= 1'b0;
      rdata_r     <= 32'd0;
      alu_hold_r  <= 32'd0;
      wreg_hold_r <= 5'd0;
      m2r_hold_r  <= 1'b0;
      rw_hold_r   <= 1'b0;
      dm_req_r    <= 1'b0;
      dm_we_r     <= 1'b0;
      dm_addr_r   <= 32'd0;
      dm_wdata_r  <= 32'd0;
      bus_err     <= 1'b0;
      memdataWB   <= 32'd0;
      ALUresultWB <= 32'd0;
      writeregWB  <= 5'd0;
      MemtoRegWB  <= 1'b0;
      RegWriteWB  <= 1'b0;
    end else begin
      // A bubble unless the state below hands an instruction to write-back.
      memdataWB   <= 32'd0;
      ALUresultWB <= 32'd0;
      writeregWB  <= 5'd0;
      MemtoRegWB  <= 1'b0;
      RegWriteWB  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            // A store wins over a simultaneous load request.
            dm_req_r    <= 1'b1;
            dm_we_r     <= MemWriteMEM;
            dm_addr_r   <= ALUresultMEM;
            dm_wdata_r  <= dmemdata;
            wait_cnt_r  <= 8'd0;
            squash_r    <= 1'b0;
            alu_hold_r  <= ALUresultMEM;
            wreg_hold_r <= writeregMEM;
            m2r_hold_r  <= MemtoRegMEM;
            rw_hold_r   <= RegWriteMEM;
            state_r     <= ACCESS;
          end else begin
            ALUresultWB <= ALUresultMEM;
            writeregWB  <= writeregMEM;
            MemtoRegWB  <= MemtoRegMEM;
            RegWriteWB  <= RegWriteMEM & ~misalign_s;
          end
        end
        ACCESS: begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
          if (dmem.dm_ack) begin
            rdata_r  <= dm_we_r ? 32'd0 : dmem.dm_rdata;
            dm_req_r <= 1'b0;
            state_r  <= DONE;
          end else if (timeout_s) begin
            rdata_r  <= 32'd0;
            dm_req_r <= 1'b0;
            bus_err  <= 1'b1;
            squash_r <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r <= ACCESS;
          end
        end
        DONE: begin
          // EX/MEM advances on this edge, so the finished instruction cannot restart.
          memdataWB   <= squash_r ? 32'd0 : rdata_r;
          ALUresultWB <= alu_hold_r;
          writeregWB  <= wreg_hold_r;
          MemtoRegWB  <= m2r_hold_r;
          RegWriteWB  <= rw_hold_r & ~squash_r;
          state_r     <= IDLE;
        end
        default: begin
          dm_req_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized self-checking bench for mem_stage_ctrl.
// The bench plays both the EX/MEM producer and the data memory. Expectations are
// transaction level: each instruction yields one write-back record, an access
// costs (ack delay + 2) stall cycles or (TIMEOUT + 1) on abort, and every stall
// cycle is followed by a bubble in MEM/WB.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUresultMEM, dmemdata;
  logic [4:0]  writeregMEM;
  logic        MemReadMEM, MemWriteMEM, MemtoRegMEM, RegWriteMEM;
  logic        mem_stall;
  logic [31:0] memdataWB, ALUresultWB;
  logic [4:0]  writeregWB;
  logic        MemtoRegWB, RegWriteWB, bus_err, misalign;

  mem_stage_ctrl_if dmem ();

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUresultMEM(ALUresultMEM), .dmemdata(dmemdata), .writeregMEM(writeregMEM),
    .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM),
    .MemtoRegMEM(MemtoRegMEM), .RegWriteMEM(RegWriteMEM),
    .dmem(dmem),
    .mem_stall(mem_stall), .memdataWB(memdataWB), .ALUresultWB(ALUresultWB),
    .writeregWB(writeregWB), .MemtoRegWB(MemtoRegWB), .RegWriteWB(RegWriteWB),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [70:0] exp_wb;
  logic        exp_bus_err;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [70:0] wb_obs();
    return {memdataWB, ALUresultWB, writeregWB, MemtoRegWB, RegWriteWB};
  endfunction

  task automatic set_inputs(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                            input logic mr, input logic mw, input logic m2r, input logic rw);
    ALUresultMEM = alu; dmemdata = wd; writeregMEM = wreg;
    MemReadMEM = mr; MemWriteMEM = mw; MemtoRegMEM = m2r; RegWriteMEM = rw;
  endtask

  // One instruction through the MEM stage. dly < 0: memory never answers.
  task automatic do_instr(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                          input logic mr, input logic mw, input logic m2r, input logic rw,
                          input int dly, input logic [31:0] rdat);
    logic acc, misal, timed;
    int   stalls, exp_stalls;
    acc   = mr | mw;
    misal = 1'b0;
`ifdef ALIGN_CHECK_EN
    misal = acc && (alu[1:0] != 2'b00);
    acc   = acc && !misal;
`endif
    timed = acc && (dly < 0);
    @(posedge clk); #1;
    set_inputs(alu, wd, wreg, mr, mw, m2r, rw);
    dmem.dm_ack   = 1'($urandom_range(0, 1));
    dmem.dm_rdata = $urandom;
    @(negedge clk);
    check_val("wb_record", {1'b0, wb_obs()}, {1'b0, exp_wb});
    check_val("bus_err", 72'(bus_err), 72'(exp_bus_err));
    check_val("misalign", 72'(misalign), 72'(misal));
    check_val("idle_req", 72'(dmem.dm_req), 72'd0);
    check_val("idle_stall", 72'(mem_stall), 72'(acc));
    if (acc) begin
      stalls = 1;
      for (int k = 1; k <= 64; k++) begin
        @(posedge clk); #1;
        dmem.dm_rdata = $urandom;
        if (dly >= 0 && k == dly + 1) begin
          dmem.dm_ack   = 1'b1;
          dmem.dm_rdata = rdat;
        end else if ((dly >= 0 && k > dly + 1) || (dly < 0 && k > TO)) begin
          dmem.dm_ack = 1'($urandom_range(0, 1));
        end else begin
          dmem.dm_ack = 1'b0;
        end
        @(negedge clk);
        if (!mem_stall) break;
        stalls++;
        check_val("acc_req", 72'(dmem.dm_req), 72'd1);
        check_val("acc_addr", 72'(dmem.dm_addr), 72'(alu));
        check_val("acc_we", 72'(dmem.dm_we), 72'(mw));
        check_val("acc_wdata", 72'(dmem.dm_wdata), 72'(wd));
        check_val("acc_bubble", {1'b0, wb_obs()}, 72'd0);
      end
      exp_stalls = (dly < 0) ? TO + 1 : dly + 2;
      if (timed) exp_bus_err = 1'b1;
      check_val("done_stall", 72'(mem_stall), 72'd0);
      check_val("done_req", 72'(dmem.dm_req), 72'd0);
      check_val("done_bubble", {1'b0, wb_obs()}, 72'd0);
      check_val("stall_cycles", 72'(stalls), 72'(exp_stalls));
      check_val("done_bus_err", 72'(bus_err), 72'(exp_bus_err));
    end
    exp_wb = {((acc && !mw && !timed) ? rdat : 32'd0), alu, wreg, m2r, rw & ~timed & ~misal};
  endtask

  // Reset asserted while an access is outstanding abandons it and clears everything.
  task automatic reset_mid_access();
    @(posedge clk); #1;
    set_inputs(32'h0000_0080, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem.dm_ack = 1'b0;
    @(negedge clk);
    check_val("pre_rst_wb", {1'b0, wb_obs()}, {1'b0, exp_wb});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("pre_rst_req", 72'(dmem.dm_req), 72'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_stall_low", 72'(mem_stall), 72'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_req", 72'(dmem.dm_req), 72'd0);
    check_val("rst_bus_err", 72'(bus_err), 72'd0);
    check_val("rst_wb", {1'b0, wb_obs()}, 72'd0);
    check_val("rst_stall", 72'(mem_stall), 72'd0);
    set_inputs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset       = 1'b0;
    exp_wb      = 71'd0;
    exp_bus_err = 1'b0;
  endtask

  initial begin
    logic [31:0] alu, wd, rdat;
    logic [4:0]  wreg;
    logic        mr, mw, m2r, rw;
    int          r, dly;

    reset = 1'b1;
    set_inputs(32'h0000_0040, 32'h5555_AAAA, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem.dm_ack   = 1'b0;
    dmem.dm_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_stall", 72'(mem_stall), 72'd0);
    check_val("reset_req", 72'(dmem.dm_req), 72'd0);
    check_val("reset_wb", {1'b0, wb_obs()}, 72'd0);
    check_val("reset_bus_err", 72'(bus_err), 72'd0);
    check_val("reset_misalign", 72'(misalign), 72'd0);
    set_inputs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset       = 1'b0;
    exp_wb      = 71'd0;
    exp_bus_err = 1'b0;

    do_instr(32'h0000_1234, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    do_instr(32'h0000_0040, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'hDEAD_BEEF);
    do_instr(32'h0000_0044, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h1111_2222);
    do_instr(32'h0000_004C, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h0BAD_F00D);
    do_instr(32'h0000_0048, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 32'h0);
    do_instr(32'h0000_0100, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    do_instr(32'h0000_0042, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h7777_8888);
    do_instr(32'h0000_0050, 32'h1357_9BDF, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'hFFFF_0000);
    reset_mid_access();
    do_instr(32'h0000_0060, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h2468_ACE0);

    for (int i = 0; i < 150; i++) begin
      alu  = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      wreg = 5'($urandom_range(0, 31));
      r    = $urandom_range(0, 9);
      mr   = (r < 4) || (r == 9);
      mw   = (r >= 4 && r < 6) || (r == 9);
      m2r  = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      dly  = (r == 0) ? -1 : (r % 4);
      do_instr(alu, wd, wreg, mr, mw, m2r, rw, dly, rdat);
    end
    do_instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
